// File: rtl/ysyx_041514_icache_ctrl_pkg.sv
// Shared widths, FSM encoding and request bundle
// for the direct-mapped icache controller.
package ysyx_041514_icache_ctrl_pkg;

  localparam int IDX_LEN = 6;
  localparam int BLK_LEN = 6;
  localparam int TAG_LEN = 32 - IDX_LEN - BLK_LEN;
  localparam int SETS    = 1 << IDX_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL
  } state_e;

  typedef struct packed {
    logic [TAG_LEN-1:0] tag;
    logic [IDX_LEN-1:0] idx;
    logic [BLK_LEN-1:0] blk;
  } areq_t;

  // Odd beats land in the upper half of a 128-bit bank.
  function automatic logic [127:0] beat_mask(input logic [2:0] cnt);
    return cnt[0] ? {{64{1'b1}}, 64'h0} : {64'h0, {64{1'b1}}};
  endfunction

endpackage

// File: rtl/ysyx_041514_icache_tag.sv
// Tag registers and valid bits: one write port,
// combinational compare against the latched request.
module ysyx_041514_icache_tag
  import ysyx_041514_icache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_LEN-1:0] rd_idx_i,
  input  logic [TAG_LEN-1:0] rd_tag_i,
  output logic               hit_o,
  input  logic               we_i,
  input  logic [IDX_LEN-1:0] wr_idx_i,
  input  logic [TAG_LEN-1:0] wr_tag_i,
  input  logic               clr_i
);

  logic [TAG_LEN-1:0] tag_q [SETS];
  logic [TAG_LEN-1:0] tag_d [SETS];
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    valid_d;

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    if (we_i) begin
      tag_d[wr_idx_i]   = wr_tag_i;
      valid_d[wr_idx_i] = 1'b1;
    end
    if (clr_i) valid_d = '0;
  end

  // Tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  assign hit_o = valid_q[rd_idx_i] &&
                 (tag_q[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/ysyx_041514_icache_ctrl.sv
// Direct-mapped icache controller with 8-beat refill.
// Define YSYX_041514_ICACHE_FLUSH_EN to add fence.i flush.
module ysyx_041514_icache_ctrl
  import ysyx_041514_icache_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ifu_req_valid_i,
  output logic         ifu_req_ready_o,
  input  logic [31:0]  ifu_addr_i,
  output logic         ifu_resp_valid_o,
  output logic [31:0]  ifu_rdata_o,
  output logic         mem_ar_valid_o,
  input  logic         mem_ar_ready_i,
  output logic [31:0]  mem_ar_addr_o,
  input  logic         mem_r_valid_i,
  input  logic [63:0]  mem_r_data_i,
  input  logic         mem_r_last_i,
  output logic         mem_r_ready_o,
  output logic [5:0]   icache_index_o,
  output logic [5:0]   icache_blk_addr_o,
  output logic [127:0] icache_line_wdata_o,
  output logic [127:0] icache_wmask_o,
  output logic [2:0]   burst_count_o,
  output logic         icache_wen_o,
  input  logic [63:0]  icache_rdata_i
`ifdef YSYX_041514_ICACHE_FLUSH_EN
  ,
  input  logic         flush_i
`endif
);

  state_e     state_q, state_d;
  areq_t      areq_q, areq_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rdy_q;
  logic       hit;
  logic       tag_we;
  logic       flush_now;
  logic       flush_block;
  logic       unused_hi;

`ifdef YSYX_041514_ICACHE_FLUSH_EN
  logic flush_pend_q, flush_pend_d;

  assign flush_block  = flush_pend_q | flush_i;
  assign flush_now    = (state_q == S_IDLE) & flush_block;
  assign flush_pend_d = flush_now ? 1'b0 : flush_block;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_pend_q <= 1'b0;
    else      flush_pend_q <= flush_pend_d;
  end
`else
  assign flush_block = 1'b0;
  assign flush_now   = 1'b0;
`endif

  assign unused_hi = ^icache_rdata_i[63:32];

  assign ifu_req_ready_o = rdy_q & (state_q == S_IDLE) & ~flush_block;

  assign mem_ar_addr_o       = {areq_q.tag, areq_q.idx, {BLK_LEN{1'b0}}};
  assign icache_index_o      = areq_q.idx;
  assign icache_blk_addr_o   = areq_q.blk;
  assign icache_line_wdata_o = {2{mem_r_data_i}};
  assign icache_wmask_o      = beat_mask(cnt_q);
  assign burst_count_o       = cnt_q;

  always_comb begin
    state_d          = state_q;
    areq_d           = areq_q;
    cnt_d            = cnt_q;
    tag_we           = 1'b0;
    ifu_resp_valid_o = 1'b0;
    ifu_rdata_o      = '0;
    mem_ar_valid_o   = 1'b0;
    mem_r_ready_o    = 1'b0;
    icache_wen_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_req_valid_i && ifu_req_ready_o) begin
          areq_d  = areq_t'(ifu_addr_i);
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          ifu_resp_valid_o = 1'b1;
          ifu_rdata_o      = icache_rdata_i[31:0];
          state_d          = S_IDLE;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_ar_valid_o = 1'b1;
        if (mem_ar_ready_i) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_r_ready_o = 1'b1;
        if (mem_r_valid_i) begin
          icache_wen_o = 1'b1;
          cnt_d        = cnt_q + 3'd1;
          // r_last ends the burst regardless of the beat count.
          if (mem_r_last_i) begin
            tag_we  = 1'b1;
            state_d = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      areq_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      areq_q  <= areq_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  ysyx_041514_icache_tag u_tag (
    .clk      (clk),
    .rst      (rst),
    .rd_idx_i (areq_q.idx),
    .rd_tag_i (areq_q.tag),
    .hit_o    (hit),
    .we_i     (tag_we),
    .wr_idx_i (areq_q.idx),
    .wr_tag_i (areq_q.tag),
    .clr_i    (flush_now)
  );

endmodule
